// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller for the E pipeline stage.
//
// Accepts mult/multu/div/divu/mthi/mtlo from the E stage. Arithmetic ops
// compute their full result immediately into pending registers (phi/plo).
// The block then holds busy for a fixed number of cycles and finally commits
// the pending pair into the architectural HI/LO. mthi/mtlo write HI/LO at the
// accepting edge with no busy time. Reads (mfhi/mflo) only ever see the
// committed HI/LO.
//
// Parameters
//   MULT_CYCLES : busy cycles for mult/multu (1..15)
//   DIV_CYCLES  : busy cycles for div/divu   (1..15)
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high reset
//   E_mdu_op   : 000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                101 mthi, 110 mtlo, 111 reserved (ignored)
//   E_kill     : cancels the E-stage op this cycle (does not abort busy)
//   E_rs/E_rt  : operands (E_rs also carries mthi/mtlo data)
//   E_rd_hi    : read select, 1 = HI, 0 = LO
//   D_is_mdu   : D-stage instruction uses the MDU
//   E_mdu_out  : committed HI or LO
//   busy       : an arithmetic op is in flight
//   stall_req  : stall request to the hazard unit
// -----------------------------------------------------------------------------
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_mdu_op,
  input  logic        E_kill,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        E_rd_hi,
  input  logic        D_is_mdu,
  output logic [31:0] E_mdu_out,
  output logic        busy,
  output logic        stall_req
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_RSVD  = 3'b111
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [31:0] phi_q,   phi_d;
  logic [31:0] plo_q,   plo_d;

  // ---------------------------------------------------------------------------
  // Result datapath (purely combinational from the E operands)
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s, prod_u;
  logic        rs_neg, rt_neg, rt_zero;
  logic [31:0] abs_rs, abs_rt_safe, rt_safe;
  logic [31:0] qa, ra, q_s, r_s, q_u, r_u;

  assign prod_s = $signed({{32{E_rs[31]}}, E_rs}) * $signed({{32{E_rt[31]}}, E_rt});
  assign prod_u = {32'd0, E_rs} * {32'd0, E_rt};

  assign rs_neg  = E_rs[31];
  assign rt_neg  = E_rt[31];
  assign rt_zero = (E_rt == 32'd0);
  assign abs_rs  = rs_neg ? (32'd0 - E_rs) : E_rs;

  // A zero divisor is replaced by 1 only to keep the dividers well defined;
  // its result is discarded because the commit rewrites the current HI/LO.
  assign rt_safe     = rt_zero ? 32'd1 : E_rt;
  assign abs_rt_safe = rt_zero ? 32'd1 : (rt_neg ? (32'd0 - E_rt) : E_rt);

  // Signed division on magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign qa  = abs_rs / abs_rt_safe;
  assign ra  = abs_rs % abs_rt_safe;
  assign q_s = (rs_neg ^ rt_neg) ? (32'd0 - qa) : qa;
  assign r_s = rs_neg ? (32'd0 - ra) : ra;

  assign q_u = E_rs / rt_safe;
  assign r_u = E_rs % rt_safe;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;

    unique case (state_q)
      IDLE: begin
        if (!E_kill) begin
          unique case (mdu_op_e'(E_mdu_op))
            OP_MULT: begin
              phi_d   = prod_s[63:32];
              plo_d   = prod_s[31:0];
              cnt_d   = 4'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_MULTU: begin
              phi_d   = prod_u[63:32];
              plo_d   = prod_u[31:0];
              cnt_d   = 4'(MULT_CYCLES);
              state_d = BUSY;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero still runs the full latency but commits the
              // unchanged HI/LO; nothing can write HI/LO while busy.
              if (rt_zero) begin
                phi_d = hi_q;
                plo_d = lo_q;
              end else if (E_mdu_op == OP_DIV) begin
                phi_d = r_s;
                plo_d = q_s;
              end else begin
                phi_d = r_u;
                plo_d = q_u;
              end
              cnt_d   = 4'(DIV_CYCLES);
              state_d = BUSY;
            end
            OP_MTHI: hi_d = E_rs;
            OP_MTLO: lo_d = E_rs;
            OP_NONE, OP_RSVD: ;
            default: ;
          endcase
        end
      end

      BUSY: begin
        // New ops and E_kill are ignored here; the count always runs out.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      phi_q   <= 32'd0;
      plo_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic op_start;
  assign op_start = (E_mdu_op >= 3'd1) && (E_mdu_op <= 3'd4) && !E_kill;

  assign busy      = (state_q == BUSY);
  assign stall_req = D_is_mdu && (busy || op_start);
  assign E_mdu_out = E_rd_hi ? hi_q : lo_q;

endmodule
